fp_compare_pipe: RTL
====================

// Module: fp_compare_pipe
// PURPOSE
// - Pipelined, parametrised compare of two FloPoCo-format floats; successor to the subtractor-based <= check.
// - Decodes operands directly (no FPSub), so no subtractor latency or rounding dependence.
// - Supports six predicates selected per transaction; flags NaN (unordered) inputs.
// - Valid/ready on both sides; sits between ray-slab t-value producers and AABB hit logic.
// PARAMETERS
// - WE      11  exponent width; word = {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
// - WF      22  fraction width
// - STAGES  2   pipeline depth, legal 1..8; latency in unstalled cycles
// PORTS
// - clk        in   1          clock, rising edge
// - rst        in   1          reset, asynchronous, active-high
// - in_valid   in   1          inA/inB/op valid this cycle
// - in_ready   out  1          block accepts when in_valid & in_ready
// - inA        in   WE+WF+3    operand A (FloPoCo encoding)
// - inB        in   WE+WF+3    operand B
// - op         in   3          000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 11x reserved
// - out_valid  out  1          result/unordered valid
// - out_ready  in   1          consumer accepts when out_valid & out_ready
// - result     out  1          predicate (A op B)
// - unordered  out  1          1 if either operand NaN (exc=11)
// BEHAVIOUR
// - Reset: all stage valid bits, out_valid, result, unordered = 0; in-flight data discarded (also mid-stream).
// - exc: 00 zero, 01 normal, 10 inf, 11 NaN. +0 == -0 (sign ignored when exc=00).
// - Order key: exc (00<01<10), then exp, then frac, all unsigned; sign flips order for negatives.
// - NaN on either input: unordered=1, result=1 only for NE, 0 for all else.
// - Reserved op: result=0, unordered still computed.
// - Compare computed combinationally into stage 1 register; stages 2..STAGES delay only.
// - Latency: transaction accepted at edge N appears at out_valid after edge N+STAGES-1 (STAGES cycles incl. accept).
// - Stall: stall = out_valid & ~out_ready; in_ready = ~stall. On stall every stage holds (valid+data).
// - Bubbles are not collapsed; throughput 1/cycle with out_ready held high.
// - Accept and output handshake in same cycle both take effect (pipeline advances).
// - Outputs hold stable while out_valid & ~out_ready; result/unordered undefined-but-held when out_valid=0.
// CONFIGURATION
// - FPCMP_MINMAX_EN defined: extra ports min_out, max_out (out, WE+WF+3), pipelined alongside result.
//   min/max by same ordering; one NaN -> return the other; both NaN -> inA; +0/-0 tie -> min=-0, max=+0.
// - FPCMP_MINMAX_EN undefined: ports and their registers absent; all other behaviour identical.
// TESTING
// - Reset mid-stream: issue 3 ops, assert rst -> out_valid=0 next cycle, no stale result after release.
// - Default params, op=LE, A=+1.0 (exc01,exp 1023,frac0), B=+2.0 (exp 1024) -> result=1, unordered=0, 2 cycles later.
// - op=EQ, A=+0 (exc00,sign0), B=-0 (exc00,sign1) -> result=1; op=LT same operands -> result=0.
// - op=GT, A=-3.0, B=+inf (exc10) -> result=0; op=LT -> 1; A=-inf vs B=-1.0 op=LT -> 1.
// - A=NaN (exc11), B=+1.0: op=NE -> result=1, unordered=1; op=GE -> result=0, unordered=1.
// - Backpressure: stream 10 back-to-back ops, hold out_ready=0 for 4 cycles -> in_ready=0 during stall, no loss/dup,
//   order preserved; with FPCMP_MINMAX_EN, A=-1.0,B=+0.5 -> min_out=A, max_out=B.

Source files
------------

// File: rtl/fp_compare_pipe.sv
// Pipelined compare of two FloPoCo floats with six predicates, NaN flagging and valid/ready flow control.
// Define FPCMP_MINMAX_EN to add pipelined min_out/max_out ports.
module fp_compare_pipe #(
  parameter int WE     = 11,
  parameter int WF     = 22,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WE+WF+2:0]    inA,
  input  logic [WE+WF+2:0]    inB,
  input  logic [2:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                result,
  output logic                unordered
`ifdef FPCMP_MINMAX_EN
  ,
  output logic [WE+WF+2:0]    min_out,
  output logic [WE+WF+2:0]    max_out
`endif
);

  localparam int W  = WE + WF + 3;
  localparam int MW = WE + WF + 2;

  logic [1:0]    exc_a, exc_b;
  logic          nan_a, nan_b, neg_a, neg_b;
  logic [MW-1:0] mag_a, mag_b;
  logic          lt, eq;
  logic          res_d, unord_d;
  logic          stall;

  logic          v_q [STAGES];
  logic          r_q [STAGES];
  logic          u_q [STAGES];

  assign exc_a = inA[W-1 -: 2];
  assign exc_b = inB[W-1 -: 2];
  assign nan_a = (exc_a == 2'b11);
  assign nan_b = (exc_b == 2'b11);
  // Zeros collapse to one magnitude and never count as negative, so +0 == -0.
  assign neg_a = inA[WE+WF] & (exc_a != 2'b00);
  assign neg_b = inB[WE+WF] & (exc_b != 2'b00);
  assign mag_a = (exc_a == 2'b00) ? '0 : {exc_a, inA[WE+WF-1:0]};
  assign mag_b = (exc_b == 2'b00) ? '0 : {exc_b, inB[WE+WF-1:0]};

  assign eq = (neg_a == neg_b) && (mag_a == mag_b);
  assign lt = (neg_a != neg_b) ? neg_a : (neg_a ? (mag_a > mag_b) : (mag_a < mag_b));

  always_comb begin
    res_d   = 1'b0;
    unord_d = nan_a | nan_b;
    if (unord_d) begin
      res_d = (op == 3'b001);
    end else begin
      case (op)
        3'b000:  res_d = eq;
        3'b001:  res_d = ~eq;
        3'b010:  res_d = lt;
        3'b011:  res_d = lt | eq;
        3'b100:  res_d = ~(lt | eq);
        3'b101:  res_d = ~lt;
        default: res_d = 1'b0;
      endcase
    end
  end

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign result    = r_q[STAGES-1];
  assign unordered = u_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= 1'b0;
        r_q[s] <= 1'b0;
        u_q[s] <= 1'b0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      r_q[0] <= res_d;
      u_q[0] <= unord_d;
      for (int s = 1; s < STAGES; s++) begin
        v_q[s] <= v_q[s-1];
        r_q[s] <= r_q[s-1];
        u_q[s] <= u_q[s-1];
      end
    end
  end

`ifdef FPCMP_MINMAX_EN
  logic [W-1:0] min_d, max_d;
  logic [W-1:0] mn_q [STAGES];
  logic [W-1:0] mx_q [STAGES];

  always_comb begin
    min_d = inA;
    max_d = inA;
    if (nan_a && nan_b) begin
      min_d = inA;
      max_d = inA;
    end else if (nan_a) begin
      min_d = inB;
      max_d = inB;
    end else if (nan_b) begin
      min_d = inA;
      max_d = inA;
    end else if (exc_a == 2'b00 && exc_b == 2'b00) begin
      // Signed-zero tie: the negative zero is the minimum.
      min_d = inA[WE+WF] ? inA : inB;
      max_d = inA[WE+WF] ? inB : inA;
    end else if (lt) begin
      min_d = inA;
      max_d = inB;
    end else begin
      min_d = inB;
      max_d = inA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        mn_q[s] <= '0;
        mx_q[s] <= '0;
      end
    end else if (!stall) begin
      mn_q[0] <= min_d;
      mx_q[0] <= max_d;
      for (int s = 1; s < STAGES; s++) begin
        mn_q[s] <= mn_q[s-1];
        mx_q[s] <= mx_q[s-1];
      end
    end
  end

  assign min_out = mn_q[STAGES-1];
  assign max_out = mx_q[STAGES-1];
`endif

endmodule
